// File: rtl/seq_muldiv_ctrl.sv
// rtl/seq_muldiv_ctrl.sv - iterative unsigned multiply/divide unit on a shared ripple adder
//
// add_subtract: 32-bit ripple adder/subtractor
//   a_i, b_i   operands
//   cin_i      carry in (1 together with sub_i=1 gives a_i - b_i)
//   sub_i      1 = subtract (b_i inverted), 0 = add
//   sum_o      result
//   cout_o     carry on add, borrow on subtract (1 means a_i < b_i unsigned)
//
// seq_muldiv_ctrl: start/busy/done sequencer for MUL, MULHU, DIVU, REMU
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, op_i       request and opcode (00 MUL, 01 MULHU, 10 DIVU, 11 REMU)
//   a_i, b_i            multiplicand/dividend, multiplier/divisor
//   busy_o, done_o      not-idle flag, one-cycle completion pulse
//   result_o            result, held from done until the next accepted start

module add_subtract (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  input  logic        sub_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] bx;
  logic [32:0] c;

  assign bx   = b_i ^ {32{sub_i}};
  assign c[0] = cin_i;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end
  endgenerate

  // A subtract with no carry out of the top means a borrow occurred.
  assign cout_o = c[32] ^ sub_i;

endmodule

module seq_muldiv_ctrl #(
  parameter bit DIV0_SHORTCUT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;

  // Multiply and divide never run together, so one register set serves both:
  //   acc  = hi  (mul) / rem  (div)
  //   sh   = lo  (mul) / dq   (div)
  //   opnd = mcand (mul) / dvsr (div)
  logic [31:0] acc;
  logic [31:0] sh;
  logic [31:0] opnd;

  logic        is_div;
  logic [32:0] rs;
  logic [31:0] add_a;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        ok;
  logic [31:0] acc_nxt;
  logic [31:0] sh_nxt;
  logic        div0_fast;

  assign is_div = op_q[1];
  assign rs     = {acc, sh[31]};
  assign add_a  = is_div ? rs[31:0] : acc;

  add_subtract u_add (
    .a_i    (add_a),
    .b_i    (opnd),
    .cin_i  (is_div),
    .sub_i  (is_div),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // rs is 33 bits wide; when its top bit is set it exceeds any 32-bit
  // divisor regardless of the 32-bit borrow.
  assign ok = rs[32] | ~add_cout;

  always_comb begin
    acc_nxt = acc;
    sh_nxt  = sh;
    if (is_div) begin
      acc_nxt = ok ? add_sum : rs[31:0];
      sh_nxt  = {sh[30:0], ok};
    end else if (sh[0]) begin
      acc_nxt = {add_cout, add_sum[31:1]};
      sh_nxt  = {add_sum[0], sh[31:1]};
    end else begin
      acc_nxt = {1'b0, acc[31:1]};
      sh_nxt  = {acc[0], sh[31:1]};
    end
  end

  assign div0_fast = DIV0_SHORTCUT && op_i[1] && (b_i == 32'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      op_q     <= 2'd0;
      acc      <= 32'd0;
      sh       <= 32'd0;
      opnd     <= 32'd0;
      result_o <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op_q <= op_i;
            cnt  <= 5'd0;
            acc  <= 32'd0;
            sh   <= op_i[1] ? a_i : b_i;
            opnd <= op_i[1] ? b_i : a_i;
            if (div0_fast) begin
              state    <= S_FIN;
              result_o <= op_i[0] ? a_i : 32'hFFFF_FFFF;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          sh  <= sh_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= S_FIN;
            // MUL/DIVU take the shifting word, MULHU/REMU the accumulator.
            result_o <= op_q[0] ? acc_nxt : sh_nxt;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_FIN);

endmodule

// File: tb/tb_seq_muldiv_ctrl.sv
// tb/tb_seq_muldiv_ctrl.sv - scoreboard bench for seq_muldiv_ctrl, both div-by-zero variants

module tb_seq_muldiv_ctrl;

  typedef struct {
    logic [31:0] res;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy1, done1, busy0, done0;
  logic [31:0] res1, res0;

  logic [31:0] cyc = 32'd0;
  int          n_tests = 0;
  int          n_fail  = 0;

  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  seq_muldiv_ctrl #(.DIV0_SHORTCUT(1'b1)) u_dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy1),
    .done_o   (done1),
    .result_o (res1)
  );

  seq_muldiv_ctrl #(.DIV0_SHORTCUT(1'b0)) u_dut0 (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy0),
    .done_o   (done0),
    .result_o (res0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      2'b00:   model = p[31:0];
      2'b01:   model = p[63:32];
      2'b10:   model = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default: model = (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [31:0] lat(input logic [1:0] o, input logic [31:0] y, input bit fast);
    lat = (fast && o[1] && y == 32'd0) ? 32'd1 : 32'd33;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_result", res1, e.res);
        check("dut1_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_result", res0, e.res);
        check("dut0_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy1 && !busy0) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] edge_cyc);
    exp_t e;
    e.res = model(o, x, y);
    e.cyc = edge_cyc + lat(o, y, 1'b1);
    q1.push_back(e);
    e.cyc = edge_cyc + lat(o, y, 1'b0);
    q0.push_back(e);
  endtask

  // Drives a one-cycle start; returns at the negedge right after the accept edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] edge_cyc);
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    edge_cyc = cyc;
    push_exp(o, x, y, edge_cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] c;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy1 | busy0}, 32'd0);
    check("reset_done", {31'd0, done1 | done0}, 32'd0);
    check("reset_result1", res1, 32'd0);
    check("reset_result0", res0, 32'd0);
    rst = 1'b0;

    // MUL 7*6 with per-cycle busy/done timing.
    do_op(2'b00, 32'd7, 32'd6, c);
    for (int k = 1; k <= 34; k++) begin
      check($sformatf("mul_busy_k%0d", k), {31'd0, busy1}, {31'd0, k <= 33});
      check($sformatf("mul_done_k%0d", k), {31'd0, done1}, {31'd0, k == 33});
      @(negedge clk);
    end
    check("mul_result_held", res1, 32'd42);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    do_op(2'b10, 32'd100, 32'd7, c);
    do_op(2'b11, 32'd100, 32'd7, c);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    do_op(2'b11, 32'h8000_0000, 32'd3, c);
    do_op(2'b10, 32'd5, 32'd0, c);
    do_op(2'b11, 32'd5, 32'd0, c);

    // start_i held high across a whole op: the re-accept happens only from IDLE.
    wait_idle();
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd4;
    c     = cyc;
    push_exp(2'b00, 32'd3, 32'd4, c);
    push_exp(2'b00, 32'd3, 32'd4, c + 32'd34);
    repeat (34) @(negedge clk);
    check("hold_idle_gap_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold_reaccept_busy", {31'd0, busy1}, 32'd1);

    // Reset in the middle of a divide, at counter 10.
    do_op(2'b10, 32'd1000, 32'd3, c);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", {31'd0, busy1 | busy0}, 32'd0);
    check("midrun_rst_done", {31'd0, done1 | done0}, 32'd0);
    check("midrun_rst_result1", res1, 32'd0);
    check("midrun_rst_result0", res0, 32'd0);
    q1.delete();
    q0.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(2'b10, 32'd1000, 32'd3, c);

    // A handful of random operands, with the occasional zero divisor.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      do_op(2'($urandom_range(0, 3)), ra, rb, c);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("dut1_pending", q1.size(), 32'd0);
    check("dut0_pending", q0.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
